wb_regfile: RTL and testbench

//  Write-back stage and architectural register file: the consumer of the MEM/WB pipeline register.

---
 rtl/wb_regfile.sv | 101 ++++++++++
 tb/tb_wb_regfile.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   Write-back stage and architectural register file fed by the MEM/WB
//   pipeline register. Chooses the write-back value (load data or
//   functional-unit result), commits it to the register file, serves two
//   ID-stage read ports with same-cycle write bypass, keeps a one-cycle
//   write record for the EX forwarding unit and counts retired writes.
//
// Ports
//   clk_i          clock, all state changes on the rising edge
//   rst_i          synchronous active-high reset
//   decoder_i      [1]=RegWrite, [0]=MemtoReg
//   MemReadData_i  load data
//   FURslt_i       functional-unit result
//   instruction_i  destination register index
//   rs_addr_i      read port A address
//   rt_addr_i      read port B address
//   rs_data_o      read port A data (combinational, write-first bypass)
//   rt_data_o      read port B data (combinational, write-first bypass)
//   wb_data_o      current-cycle write-back value
//   fwd_valid_o    a non-zero-register write committed last cycle
//   fwd_addr_o     destination of that write (0 when none)
//   fwd_data_o     value of that write (0 when none)
//   wb_count_o     number of committed writes, wraps modulo 2^CNTW
// ---------------------------------------------------------------------------
module wb_regfile #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int CNTW = 32,
  localparam int AW  = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [1:0]      decoder_i,
  input  logic [DW-1:0]   MemReadData_i,
  input  logic [DW-1:0]   FURslt_i,
  input  logic [AW-1:0]   instruction_i,
  input  logic [AW-1:0]   rs_addr_i,
  input  logic [AW-1:0]   rt_addr_i,
  output logic [DW-1:0]   rs_data_o,
  output logic [DW-1:0]   rt_data_o,
  output logic [DW-1:0]   wb_data_o,
  output logic            fwd_valid_o,
  output logic [AW-1:0]   fwd_addr_o,
  output logic [DW-1:0]   fwd_data_o,
  output logic [CNTW-1:0] wb_count_o
);

  logic [DW-1:0]   rf_q [NREG];
  logic            fwd_valid_q, fwd_valid_d;
  logic [AW-1:0]   fwd_addr_q,  fwd_addr_d;
  logic [DW-1:0]   fwd_data_q,  fwd_data_d;
  logic [CNTW-1:0] cnt_q,       cnt_d;
  logic            we;

  assign wb_data_o = decoder_i[0] ? MemReadData_i : FURslt_i;

  // Register 0 is never a valid destination; reset also suppresses commit.
  assign we = decoder_i[1] && (instruction_i != '0) && !rst_i;

  // Write-first bypass lets ID see the value being committed this cycle.
  assign rs_data_o = (rs_addr_i == '0) ? '0 :
                     (we && (rs_addr_i == instruction_i)) ? wb_data_o :
                     rf_q[rs_addr_i];
  assign rt_data_o = (rt_addr_i == '0) ? '0 :
                     (we && (rt_addr_i == instruction_i)) ? wb_data_o :
                     rf_q[rt_addr_i];

  always_comb begin
    fwd_valid_d = we;
    fwd_addr_d  = we ? instruction_i : '0;
    fwd_data_d  = we ? wb_data_o : '0;
    cnt_d       = we ? cnt_q + {{(CNTW-1){1'b0}}, 1'b1} : cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      if (we) begin
        rf_q[instruction_i] <= wb_data_o;
      end
      fwd_valid_q <= fwd_valid_d;
      fwd_addr_q  <= fwd_addr_d;
      fwd_data_q  <= fwd_data_d;
      cnt_q       <= cnt_d;
    end
  end

  assign fwd_valid_o = fwd_valid_q;
  assign fwd_addr_o  = fwd_addr_q;
  assign fwd_data_o  = fwd_data_q;
  assign wb_count_o  = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
//   Drives random and directed MEM/WB traffic into two instances (32-bit
//   and 4-bit retired-write counter) and compares every output each cycle
//   against an array-based model of the architectural register file.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  decoder_i;
  logic [31:0] MemReadData_i, FURslt_i;
  logic [4:0]  instruction_i, rs_addr_i, rt_addr_i;

  logic [31:0] rs_data_o, rt_data_o, wb_data_o, fwd_data_o, wb_count_o;
  logic        fwd_valid_o;
  logic [4:0]  fwd_addr_o;

  logic [31:0] rs4, rt4, wb4, fd4;
  logic        fv4;
  logic [4:0]  fa4;
  logic [3:0]  cnt4;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  wb_regfile u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .decoder_i(decoder_i),
    .MemReadData_i(MemReadData_i), .FURslt_i(FURslt_i),
    .instruction_i(instruction_i), .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
    .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .wb_data_o(wb_data_o),
    .fwd_valid_o(fwd_valid_o), .fwd_addr_o(fwd_addr_o), .fwd_data_o(fwd_data_o),
    .wb_count_o(wb_count_o)
  );

  wb_regfile #(.CNTW(4)) u_dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .decoder_i(decoder_i),
    .MemReadData_i(MemReadData_i), .FURslt_i(FURslt_i),
    .instruction_i(instruction_i), .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
    .rs_data_o(rs4), .rt_data_o(rt4), .wb_data_o(wb4),
    .fwd_valid_o(fv4), .fwd_addr_o(fa4), .fwd_data_o(fd4),
    .wb_count_o(cnt4)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_rf [32];
  logic        m_fv = 1'b0;
  logic [4:0]  m_fa = '0;
  logic [31:0] m_fd = '0;
  longint      m_cnt = 0;

  initial for (int i = 0; i < 32; i++) m_rf[i] = '0;

  function automatic logic [31:0] m_wb();
    return decoder_i[0] ? MemReadData_i : FURslt_i;
  endfunction

  function automatic bit m_we();
    return decoder_i[1] && (instruction_i != 0) && !rst_i;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (m_we() && a == instruction_i) return m_wb();
    return m_rf[a];
  endfunction

  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_fv = 1'b0; m_fa = '0; m_fd = '0; m_cnt = 0;
    end else begin
      bit w;
      w = m_we();
      if (w) begin
        m_rf[instruction_i] = m_wb();
        m_cnt = m_cnt + 1;
      end
      m_fv = w;
      m_fa = w ? instruction_i : 5'd0;
      m_fd = w ? m_wb() : 32'd0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous compare on the falling edge, well away from the active edge.
  always @(negedge clk_i) begin
    logic [31:0] cexp;
    cexp = m_cnt[31:0];
    chk("rs_data",   rs_data_o,   m_read(rs_addr_i));
    chk("rt_data",   rt_data_o,   m_read(rt_addr_i));
    chk("wb_data",   wb_data_o,   m_wb());
    chk("fwd_valid", {31'd0, fwd_valid_o}, {31'd0, m_fv});
    chk("fwd_addr",  {27'd0, fwd_addr_o},  {27'd0, m_fa});
    chk("fwd_data",  fwd_data_o,  m_fd);
    chk("wb_count",  wb_count_o,  cexp);
    chk("cnt4",      {28'd0, cnt4}, {28'd0, cexp[3:0]});
    chk("rs4",       rs4,         m_read(rs_addr_i));
  end

  // ---------------- stimulus ----------------
  task automatic apply(input logic [1:0] dec, input logic [31:0] mem, input logic [31:0] fu,
                       input logic [4:0] ins, input logic [4:0] rs, input logic [4:0] rt,
                       input logic rst);
    decoder_i = dec; MemReadData_i = mem; FURslt_i = fu;
    instruction_i = ins; rs_addr_i = rs; rt_addr_i = rt; rst_i = rst;
    #2;
    $display("[TB] txn rst=%0b dec=%b ins=%0d mem=%h fu=%h rs=%0d rt=%0d", rst, dec, ins, mem, fu, rs, rt);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    apply(2'b00, 0, 0, 0, 0, 0, 1'b1);
    tick();
    apply(2'b00, 0, 0, 0, 0, 0, 1'b0);
    chk("reset_count", wb_count_o, 32'd0);
    chk("reset_fwd_valid", {31'd0, fwd_valid_o}, 32'd0);

    // ALU write with same-cycle bypass
    apply(2'b10, 32'h0, 32'h1234_5678, 5'd5, 5'd5, 5'd0, 1'b0);
    chk("alu_bypass", rs_data_o, 32'h1234_5678);
    tick();
    apply(2'b00, 32'h0, 32'h0, 5'd0, 5'd5, 5'd0, 1'b0);
    chk("alu_rf5", rs_data_o, 32'h1234_5678);
    chk("alu_fwd_valid", {31'd0, fwd_valid_o}, 32'd1);
    chk("alu_fwd_addr", {27'd0, fwd_addr_o}, 32'd5);
    chk("alu_count", wb_count_o, 32'd1);

    // Load write selects memory data
    apply(2'b11, 32'hDEAD_BEEF, 32'h0000_0040, 5'd31, 5'd31, 5'd0, 1'b0);
    chk("load_wb_data", wb_data_o, 32'hDEAD_BEEF);
    tick();
    apply(2'b00, 32'h0, 32'h0, 5'd0, 5'd31, 5'd0, 1'b0);
    chk("load_rf31", rs_data_o, 32'hDEAD_BEEF);
    chk("load_count", wb_count_o, 32'd2);

    // r0 guard
    apply(2'b10, 32'h0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("r0_read", rs_data_o, 32'h0);
    tick();
    apply(2'b00, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("r0_fwd_valid", {31'd0, fwd_valid_o}, 32'd0);
    chk("r0_count", wb_count_o, 32'd2);

    // Bubble after write, dual read of the same register
    apply(2'b10, 32'h0, 32'hA5A5_A5A5, 5'd7, 5'd0, 5'd0, 1'b0);
    tick();
    apply(2'b00, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7, 1'b0);
    tick();
    apply(2'b00, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7, 1'b0);
    chk("bubble_rs", rs_data_o, 32'hA5A5_A5A5);
    chk("bubble_rt", rt_data_o, 32'hA5A5_A5A5);
    chk("bubble_fwd_valid", {31'd0, fwd_valid_o}, 32'd0);
    chk("bubble_count", wb_count_o, 32'd3);

    // Counter wrap on the 4-bit instance, then reset beats a concurrent write
    apply(2'b00, 0, 0, 0, 0, 0, 1'b1);
    tick();
    for (int i = 0; i < 16; i++) begin
      apply(2'b10, 32'h0, $urandom, 5'($urandom_range(1, 8)), 5'd0, 5'd0, 1'b0);
      tick();
    end
    apply(2'b00, 0, 0, 0, 0, 0, 1'b0);
    chk("wrap_cnt4", {28'd0, cnt4}, 32'd0);
    chk("wrap_cnt32", wb_count_o, 32'd16);
    apply(2'b10, 32'h0, 32'h0000_ABCD, 5'd9, 5'd9, 5'd0, 1'b1);
    chk("rst_no_bypass", rs_data_o, 32'h0);
    tick();
    apply(2'b00, 32'h0, 32'h0, 5'd0, 5'd9, 5'd0, 1'b0);
    chk("rst_rf9", rs_data_o, 32'h0);
    chk("rst_count", wb_count_o, 32'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [4:0] ins, rs, rt;
      ins = 5'($urandom_range(0, 31));
      rs  = ($urandom_range(0, 1) == 1) ? ins : 5'($urandom_range(0, 31));
      rt  = ($urandom_range(0, 2) == 0) ? ins : 5'($urandom_range(0, 31));
      apply(2'($urandom_range(0, 3)), $urandom, $urandom, ins, rs, rt,
            ($urandom_range(0, 49) == 0));
      tick();
    end

    // Reset after random writes clears everything
    apply(2'b10, 32'h0, 32'h5555_AAAA, 5'd3, 5'd0, 5'd0, 1'b1);
    tick();
    for (int a = 1; a < 32; a++) begin
      apply(2'b00, 32'h0, 32'h0, 5'd0, 5'(a), 5'(32 - a), 1'b0);
      chk("final_reset_rs", rs_data_o, 32'h0);
      chk("final_reset_rt", rt_data_o, 32'h0);
      if (a == 1) begin
        chk("final_reset_fwd_valid", {31'd0, fwd_valid_o}, 32'd0);
        chk("final_reset_count", wb_count_o, 32'd0);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
